// File: rtl/simd_warp_sequencer.sv
// Multi-warp instruction-fetch sequencer: per-slot lifecycle, round-robin IMEM fetch,
// post-load stall, lane-completion detection and finished-warp reporting.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | slot free, may be launched
// READY     | eligible for fetch arbitration
// WAIT_RESP | fetch accepted, waiting for the decoded response
// STALL     | post-load wait, counting down LOAD_STALL
// HALTED    | halt decoded, waiting for lane completion
// DONE      | complete, queued for the finished report
module simd_warp_sequencer #(
    parameter int THREAD_COUNT = 8,
    parameter int NUM_WARPS    = 4,
    parameter int WID_W        = 2,
    parameter int TC_W         = 4,
    parameter int PC_W         = 32,
    parameter int LOAD_STALL   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              launch_valid,
    output logic                              launch_ready,
    input  logic [WID_W-1:0]                  launch_warp_id,
    input  logic [PC_W-1:0]                   launch_start_pc,
    input  logic [TC_W-1:0]                   launch_thread_count,
    output logic                              fetch_valid,
    input  logic                              fetch_ready,
    output logic [PC_W-1:0]                   fetch_pc,
    output logic [WID_W-1:0]                  fetch_warp_id,
    input  logic                              resp_valid,
    input  logic [WID_W-1:0]                  resp_warp_id,
    input  logic [2:0]                        resp_type,
    input  logic [NUM_WARPS*THREAD_COUNT-1:0] thread_complete,
    output logic [NUM_WARPS*THREAD_COUNT-1:0] active_mask,
    output logic                              finished_valid,
    input  logic                              finished_ready,
    output logic [WID_W-1:0]                  finished_warp_id,
    output logic                              busy,
    output logic                              protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_WAIT_RESP,
        S_STALL,
        S_HALTED,
        S_DONE
    } slot_state_t;

    localparam logic [2:0]      TYPE_LOAD  = 3'b110;
    localparam logic [2:0]      TYPE_HALT  = 3'b111;
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [3:0]      STALL_INIT = 4'(LOAD_STALL);

    slot_state_t             state     [NUM_WARPS];
    logic [PC_W-1:0]         pc        [NUM_WARPS];
    logic [TC_W-1:0]         tc        [NUM_WARPS];
    logic [3:0]              stall_cnt [NUM_WARPS];
    logic [WID_W-1:0]        rr_ptr;

    logic [THREAD_COUNT-1:0] lane_mask [NUM_WARPS];
    logic [NUM_WARPS-1:0]    lanes_done;
    logic [NUM_WARPS-1:0]    slot_busy;
    logic [NUM_WARPS-1:0]    fetch_hold;
    logic                    launch_fire;
    logic                    fetch_accept;
    logic                    fetch_load;
    logic                    fin_handshake;
    logic                    grant_valid;
    logic [WID_W-1:0]        grant_id;
    logic [WID_W-1:0]        rr_after_accept;
    logic                    fin_found;
    logic [WID_W-1:0]        fin_id;
    int                      search_base;
    int                      idx;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int t = 0; t < THREAD_COUNT; t++) begin
                lane_mask[w][t] = (TC_W'(t) < tc[w]);
            end
            slot_busy[w]  = (state[w] != S_IDLE);
            // a zero-lane mask makes this trivially true
            lanes_done[w] = ((thread_complete[w*THREAD_COUNT +: THREAD_COUNT] & lane_mask[w])
                             == lane_mask[w]);
            active_mask[w*THREAD_COUNT +: THREAD_COUNT] = slot_busy[w] ? lane_mask[w]
                                                                       : '0;
        end
    end

    assign busy         = |slot_busy;
    assign launch_ready = (state[launch_warp_id] == S_IDLE);
    assign launch_fire  = launch_valid & launch_ready;

    // Round-robin search starts after the slot being accepted this cycle, so a
    // new request can be presented right behind an accepted one.
    always_comb begin
        fetch_accept    = fetch_valid & fetch_ready;
        fetch_load      = ~fetch_valid | fetch_ready;
        rr_after_accept = WID_W'((int'(fetch_warp_id) + 1) % NUM_WARPS);
        search_base     = fetch_accept ? int'(rr_after_accept) : int'(rr_ptr);
        grant_valid     = 1'b0;
        grant_id        = '0;
        idx             = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (search_base + i) % NUM_WARPS;
            if (!grant_valid && state[idx] == S_READY &&
                !(fetch_accept && int'(fetch_warp_id) == idx)) begin
                grant_valid = 1'b1;
                grant_id    = WID_W'(idx);
            end
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            fetch_hold[w] = (fetch_valid && int'(fetch_warp_id) == w) ||
                            (fetch_load && grant_valid && int'(grant_id) == w);
        end
    end

    always_comb begin
        fin_handshake = finished_valid & finished_ready;
        fin_found     = 1'b0;
        fin_id        = '0;
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            if (state[w] == S_DONE && !(fin_handshake && int'(finished_warp_id) == w)) begin
                fin_found = 1'b1;
                fin_id    = WID_W'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state[w]     <= S_IDLE;
                pc[w]        <= '0;
                tc[w]        <= '0;
                stall_cnt[w] <= '0;
            end
            rr_ptr           <= '0;
            fetch_valid      <= 1'b0;
            fetch_pc         <= '0;
            fetch_warp_id    <= '0;
            finished_valid   <= 1'b0;
            finished_warp_id <= '0;
            protocol_err     <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                unique case (state[w])
                    S_IDLE: begin
                        if (launch_fire && int'(launch_warp_id) == w) begin
                            pc[w]        <= launch_start_pc;
                            tc[w]        <= launch_thread_count;
                            stall_cnt[w] <= '0;
                            state[w]     <= (launch_thread_count == '0) ? S_DONE : S_READY;
                        end
                    end
                    S_READY: begin
                        if (fetch_accept && int'(fetch_warp_id) == w) begin
                            state[w] <= S_WAIT_RESP;
                            pc[w]    <= pc[w] + PC_STEP;
                        end else if (lanes_done[w] && !fetch_hold[w]) begin
                            state[w] <= S_DONE;
                        end
                    end
                    S_WAIT_RESP: begin
                        if (resp_valid && int'(resp_warp_id) == w) begin
                            if (resp_type == TYPE_LOAD) begin
                                if (LOAD_STALL == 0) begin
                                    state[w] <= S_READY;
                                end else begin
                                    state[w]     <= S_STALL;
                                    stall_cnt[w] <= STALL_INIT;
                                end
                            end else if (resp_type == TYPE_HALT) begin
                                state[w] <= S_HALTED;
                            end else begin
                                state[w] <= S_READY;
                            end
                        end
                    end
                    S_STALL: begin
                        if (lanes_done[w]) begin
                            state[w]     <= S_DONE;
                            stall_cnt[w] <= '0;
                        end else if (stall_cnt[w] <= 4'd1) begin
                            state[w]     <= S_READY;
                            stall_cnt[w] <= '0;
                        end else begin
                            stall_cnt[w] <= stall_cnt[w] - 4'd1;
                        end
                    end
                    S_HALTED: begin
                        if (lanes_done[w]) begin
                            state[w] <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (fin_handshake && int'(finished_warp_id) == w) begin
                            state[w] <= S_IDLE;
                        end
                    end
                    default: state[w] <= S_IDLE;
                endcase
            end

            if (resp_valid && state[resp_warp_id] != S_WAIT_RESP) begin
                protocol_err <= 1'b1;
            end

            if (fetch_accept) begin
                rr_ptr <= rr_after_accept;
            end

            // request registers only move when the previous one is gone or accepted
            if (fetch_load) begin
                fetch_valid <= grant_valid;
                if (grant_valid) begin
                    fetch_pc      <= pc[grant_id];
                    fetch_warp_id <= grant_id;
                end
            end

            if (!finished_valid || finished_ready) begin
                finished_valid <= fin_found;
                if (fin_found) begin
                    finished_warp_id <= fin_id;
                end
            end
        end
    end

endmodule

// File: doc/simd_warp_sequencer.md
Name: simd_warp_sequencer

Overview:
Multi-warp instruction-fetch sequencer, the parametrised successor of the single-warp SIMD core control path. It holds up to NUM_WARPS resident warps, each with its own PC and thread count. It issues fetches to IMEM round-robin, applies a configurable load stall, and detects per-warp completion from the functional-unit done bits. Finished warp IDs are reported back to the kernel dispatcher over a valid/ready handshake.

Parameters:
THREAD_COUNT, 8, threads per warp (lanes).
NUM_WARPS, 4, resident warp slots.
WID_W, 2, warp-id width, equal to clog2(NUM_WARPS).
TC_W, 4, thread-count width, equal to clog2(THREAD_COUNT+1).
PC_W, 32, PC width.
LOAD_STALL, 1, extra cycles a warp waits after a load-type (3'b110) response; range 0..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
launch_valid  in  1  dispatcher offers a warp.
launch_ready  out  1  slot[launch_warp_id] is IDLE (combinational).
launch_warp_id  in  WID_W  target slot.
launch_start_pc  in  PC_W  first instruction address.
launch_thread_count  in  TC_W  number of active lanes, 0..THREAD_COUNT.
fetch_valid  out  1  fetch request.
fetch_ready  in  1  IMEM accepts.
fetch_pc  out  PC_W  instruction address.
fetch_warp_id  out  WID_W  requesting warp.
resp_valid  in  1  decoded instruction returned.
resp_warp_id  in  WID_W  warp the response belongs to.
resp_type  in  3  decoded type_instruction; 3'b110 = load, 3'b111 = halt.
thread_complete  in  NUM_WARPS*THREAD_COUNT  done bits; bit w*THREAD_COUNT+t belongs to warp w, lane t.
active_mask  out  NUM_WARPS*THREAD_COUNT  lane enables per warp, bit = (t < thread_count) while the slot is not IDLE.
finished_valid  out  1  a warp has finished.
finished_ready  in  1  dispatcher consumes the report.
finished_warp_id  out  WID_W  finished warp.
busy  out  1  any slot not IDLE.
protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async):
  - all slots IDLE; PCs, thread counts and stall counters = 0; round-robin pointer = 0.
  - fetch_valid=0, fetch_pc=0, fetch_warp_id=0, finished_valid=0, finished_warp_id=0, busy=0, protocol_err=0, active_mask=0.
  - Reset mid-operation discards all warps; in-flight responses after reset release set protocol_err.
- Slot states: IDLE, READY, WAIT_RESP, STALL, HALTED, DONE.
- Launch: on launch_valid & launch_ready, slot gets pc=start_pc and tc=thread_count.
  - Next state is READY, or DONE if thread_count==0.
  - launch_valid to a non-IDLE slot is held off (ready=0). It is not an error.
- Fetch:
  - fetch_valid/pc/warp_id are registered. The arbiter picks the next READY slot round-robin, starting after the last granted slot.
  - Outputs are held stable while fetch_valid & !fetch_ready.
  - On acceptance: slot goes to WAIT_RESP, its pc += 4 (wraps modulo 2^PC_W), and the pointer advances.
  - A new request may be presented the cycle after acceptance. One outstanding fetch per warp.
- Response to a slot in WAIT_RESP:
  - 3'b110: go to STALL and load the counter with LOAD_STALL. Decrement each cycle; go to READY when it reaches 0. LOAD_STALL=0 goes to READY directly.
  - 3'b111: go to HALTED; no further fetches.
  - Any other type: go to READY.
- A response for a slot not in WAIT_RESP is ignored and sets protocol_err.
- Completion: all masked lanes of slot w set in thread_complete while w is in READY, STALL or HALTED -> DONE next cycle.
  - In WAIT_RESP, completion is evaluated only after the response is consumed.
  - A zero-lane warp is complete trivially.
- Reporting:
  - finished_valid presents the lowest-index DONE slot, registered and held until finished_ready.
  - On handshake the slot returns to IDLE. It may be relaunched the next cycle.
- Simultaneous events:
  - A launch and a finish handshake on the same slot in one cycle are impossible, because launch_ready=0 while the slot is DONE.
  - A fetch grant and completion in the same cycle: the grant wins, and completion is taken after the response.
- busy = OR of (slot != IDLE).

Test Plan:
- Launch warp 0 (pc 0x100, tc 8); respond with type 3'b000 for each fetch -> fetch_pc sequence 0x100, 0x104, 0x108; set all 8 done bits -> finished_valid with id 0; handshake -> busy=0.
- Launch warps 0..3 (pc 0x000/0x100/0x200/0x300) with fetch_ready=1 -> fetch_warp_id 0,1,2,3,0; fetch_ready=0 for 3 cycles -> outputs held.
- LOAD_STALL=3; warp 1 gets a 3'b110 response -> no warp-1 fetch for 3 cycles, then pc +4 resumes; other warps keep fetching.
- tc=3 launch -> active_mask lanes 0..2 only; lanes 0..2 done (lanes 3..7 = 0) -> finished; tc=0 launch -> finished in 2 cycles with no fetch.
- Warps 2 and 1 DONE simultaneously, finished_ready=0 for 4 cycles -> id 1 held, then id 2; a resp for an IDLE warp -> protocol_err=1 sticky; rst low mid-stream -> all outputs 0 immediately.
